t1_idle_tracker: RTL and testbench
==================================

# t1_idle_tracker

- Synthesizable observer that produces the `idle` level consumed by the testbench clock/watchdog generator.
- Counts outstanding AXI read and write bursts on the DUT memory port and tracks a core-busy level.
- Once the cosim side requests quit, asserts `idle` only after a configurable run of consecutive quiet cycles.
- Sits between the DUT's AXI master interface (passive taps) and the clock generator's `idle` input.

## Interface

Parameters:
- `OUTSTANDING_W`, default 8: width of each outstanding-burst counter.
- `QUIET_CYCLES`, default 16: consecutive quiet cycles required before `idle`. Legal range 1..65535.

Ports:
- `clock` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `initFlag` in 1: while high, counters held at zero, FSM held in RUN.
- `ar_fire` in 1: arvalid & arready.
- `r_last_fire` in 1: rvalid & rready & rlast.
- `aw_fire` in 1: awvalid & awready.
- `b_fire` in 1: bvalid & bready.
- `core_busy` in 1: DUT reports non-idle pipeline.
- `quit` in 1: level from cosim; high means the DPI side has finished.
- `idle` out 1: registered idle indication.
- `rd_outstanding` out OUTSTANDING_W: open read bursts.
- `wr_outstanding` out OUTSTANDING_W: open write bursts.
- `error` out 1: sticky protocol error.
- `error_code` out 2: 0 none, 1 underflow, 2 overflow; captures the first error only.

## Operation

Counters:
- rd += ar_fire − r_last_fire; wr += aw_fire − b_fire.
- Simultaneous issue and retire in the same cycle gives a net change of 0.
- Underflow (retire with count 0 and no same-cycle issue): count stays 0, error set, code 1.
- Overflow (issue at all-ones with no same-cycle retire): count saturates, error set, code 2.
- Simultaneous underflow on one channel and overflow on the other: code 1 wins.
- error/error_code clear only on reset.

Qualifying cycle: registered rd and wr both 0, all four fire inputs low, core_busy low.

FSM:
- RUN: idle 0, quiet_cnt 0.
  - quit high → DRAIN.
- DRAIN: idle 0.
  - Qualifying cycle → quiet_cnt++.
  - Non-qualifying cycle → quiet_cnt cleared to 0.
  - Qualifying cycle when quiet_cnt == QUIET_CYCLES−1 → IDLE.
- IDLE: idle 1.
  - Any non-qualifying cycle → DRAIN with quiet_cnt 0.
- Any state: quit low → RUN. This has priority over all other transitions.
- initFlag high forces RUN and zeroes the counters, but does not clear error.

## Timing

- Reset values: idle 0, rd_outstanding 0, wr_outstanding 0, error 0, error_code 0, FSM RUN, quiet_cnt 0.
- Counter outputs update the cycle after the fire.
- quit rising at cycle t with the bus already quiet:
  - DRAIN at t+1.
  - Qualifying cycles t+1 .. t+QUIET_CYCLES.
  - idle high from t+QUIET_CYCLES+1.
- idle falls one cycle after the first non-qualifying cycle or after quit falls.
- A fire in the last quiet cycle of DRAIN resets quiet_cnt; no IDLE entry that cycle.
- Reset asserted mid-DRAIN returns to RUN and clears all state on the next edge.
- quiet_cnt width is $clog2(QUIET_CYCLES+1) and never wraps.

## Configuration

`T1_IDLE_TRACKER_STATS_EN`:
- Defined:
  - Adds 64-bit outputs `rd_total` and `wr_total`, counting ar_fire and aw_fire since reset. Both wrap modulo 2^64.
  - Adds a 64-bit `drain_cycles` output counting cycles spent in DRAIN.
  - All three stats outputs reset to 0.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

## Structure

- Shared package `t1_tb_pkg`:
  - FSM enum `idle_state_e` {RUN, DRAIN, IDLE}.
  - Error-code enum {ERR_NONE, ERR_UNDERFLOW, ERR_OVERFLOW}.
- One sub-module `t1_idle_burst_counter`:
  - Saturating up/down counter with underflow/overflow flags.
  - Instantiated twice, once for reads and once for writes.
- FSM and quiet counter live in the top module.

## Test plan

- **Simple drain.** Reset, 3 ar_fire then 3 r_last_fire, quit high at cycle 20, bus quiet → idle high at cycle 20+16+1=37.
- **Quiet-count restart.** quit high with QUIET_CYCLES=16; aw_fire at quiet cycle 15; b_fire 4 cycles later → quiet_cnt restarts and idle rises 16 qualifying cycles after the b_fire cycle.
- **Net-zero counters.** ar_fire and r_last_fire every cycle for 100 cycles with rd=1 → rd_outstanding stays 1, error 0.
- **Underflow.** r_last_fire with rd=0 → error=1, error_code=1 next cycle. A later overflow leaves code 1.
- **Overflow.** OUTSTANDING_W=2, 4 ar_fire → rd_outstanding=3, error_code=2.
- **Leaving IDLE.** In IDLE, core_busy pulse → idle 0 next cycle. Then quit low → RUN. Reset mid-DRAIN → all outputs 0 next cycle.

Source files
------------

// File: rtl/t1_tb_pkg.sv
// Shared types for the idle tracker: FSM states and sticky error codes.
package t1_tb_pkg;

    // Drain FSM states
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        IDLE  = 2'd2
    } idle_state_e;

    // First-error capture codes
    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_UNDERFLOW = 2'd1,
        ERR_OVERFLOW  = 2'd2
    } err_code_e;

    // Width of the optional statistics counters
    localparam int STATS_W = 64;

endpackage

// File: rtl/t1_idle_burst_counter.sv
// Saturating up/down counter of outstanding bursts on one AXI channel pair.
// Flags an underflow (retire at zero) or overflow (issue at all-ones) in the
// same cycle the offending fire is seen; the count never wraps.
import t1_tb_pkg::*;

module t1_idle_burst_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         underflow,
    output logic         overflow
);

    // Error detection for this cycle; suppressed while the counter is held clear
    always_comb begin
        underflow = !clear && dec && !inc && (count == '0);
        overflow  = !clear && inc && !dec && (count == '1);
    end

    // Count register: net change of issue minus retire, saturating at both ends
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset || clear) begin
            count <= '0;
        end else if (inc && !dec && !overflow) begin
            count <= count + W'(1);
        end else if (dec && !inc && !underflow) begin
            count <= count - W'(1);
        end
    end

endmodule

// File: rtl/t1_idle_tracker.sv
// Idle tracker: counts outstanding AXI bursts, watches core_busy and, once the
// cosim side raises quit, asserts idle after QUIET_CYCLES consecutive quiet
// cycles. Optional statistics outputs are enabled by T1_IDLE_TRACKER_STATS_EN.
import t1_tb_pkg::*;

module t1_idle_tracker #(
    parameter int OUTSTANDING_W = 8,
    parameter int QUIET_CYCLES  = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     initFlag,
    input  logic                     ar_fire,
    input  logic                     r_last_fire,
    input  logic                     aw_fire,
    input  logic                     b_fire,
    input  logic                     core_busy,
    input  logic                     quit,
    output logic                     idle,
    output logic [OUTSTANDING_W-1:0] rd_outstanding,
    output logic [OUTSTANDING_W-1:0] wr_outstanding,
    output logic                     error,
    output logic [1:0]               error_code
`ifdef T1_IDLE_TRACKER_STATS_EN
    ,
    output logic [STATS_W-1:0]       rd_total,
    output logic [STATS_W-1:0]       wr_total,
    output logic [STATS_W-1:0]       drain_cycles
`endif
);

    localparam int QW = $clog2(QUIET_CYCLES + 1);
    localparam logic [QW-1:0] QUIET_LAST = QW'(QUIET_CYCLES - 1);

    idle_state_e   state, state_n;
    logic [QW-1:0] quiet_cnt, quiet_n;
    err_code_e     err_q;
    logic          rd_uf, rd_of, wr_uf, wr_of;
    logic          qualifying;

    t1_idle_burst_counter #(.W(OUTSTANDING_W)) u_rd (
        .clock     (clock),
        .reset     (reset),
        .clear     (initFlag),
        .inc       (ar_fire),
        .dec       (r_last_fire),
        .count     (rd_outstanding),
        .underflow (rd_uf),
        .overflow  (rd_of)
    );

    t1_idle_burst_counter #(.W(OUTSTANDING_W)) u_wr (
        .clock     (clock),
        .reset     (reset),
        .clear     (initFlag),
        .inc       (aw_fire),
        .dec       (b_fire),
        .count     (wr_outstanding),
        .underflow (wr_uf),
        .overflow  (wr_of)
    );

    assign error_code = err_q;

    // A cycle is quiet when nothing is open, nothing fires and the core is idle
    assign qualifying = (rd_outstanding == '0) && (wr_outstanding == '0) &&
                        !ar_fire && !r_last_fire && !aw_fire && !b_fire &&
                        !core_busy;

    // Sticky first-error capture; underflow outranks a simultaneous overflow
    always_ff @(posedge clock) begin
        if (reset) begin
            error <= 1'b0;
            err_q <= ERR_NONE;
        end else if (!error) begin
            if (rd_uf || wr_uf) begin
                error <= 1'b1;
                err_q <= ERR_UNDERFLOW;
            end else if (rd_of || wr_of) begin
                error <= 1'b1;
                err_q <= ERR_OVERFLOW;
            end
        end
    end

    // Next-state and quiet-count logic; quit low or initFlag always wins
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        state_n = state;
        quiet_n = quiet_cnt;
        if (initFlag || !quit) begin
            state_n = RUN;
            quiet_n = '0;
        end else begin
            unique case (state)
                RUN: begin
                    state_n = DRAIN;
                    quiet_n = '0;
                end
                DRAIN: begin
                    if (!qualifying) begin
                        quiet_n = '0;
                    end else if (quiet_cnt == QUIET_LAST) begin
                        state_n = IDLE;
                        quiet_n = '0;
                    end else begin
                        quiet_n = quiet_cnt + QW'(1);
                    end
                end
                IDLE: begin
                    if (!qualifying) begin
                        state_n = DRAIN;
                        quiet_n = '0;
                    end
                end
                default: begin
                    state_n = RUN;
                    quiet_n = '0;
                end
            endcase
        end
    end

    // State, quiet counter and registered idle output
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= RUN;
            quiet_cnt <= '0;
            idle      <= 1'b0;
        end else begin
            state     <= state_n;
            quiet_cnt <= quiet_n;
            idle      <= (state_n == IDLE);
        end
    end

`ifdef T1_IDLE_TRACKER_STATS_EN
    // Free-running statistics, cleared only by reset and wrapping at 2^64
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_total     <= '0;
            wr_total     <= '0;
            drain_cycles <= '0;
        end else begin
            if (ar_fire)        rd_total     <= rd_total + STATS_W'(1);
            if (aw_fire)        wr_total     <= wr_total + STATS_W'(1);
            if (state == DRAIN) drain_cycles <= drain_cycles + STATS_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_t1_idle_tracker.sv
// Directed bench for t1_idle_tracker: a default instance (W=8, 16 quiet
// cycles) and a small instance (W=2, 3 quiet cycles) for saturation cases.
`timescale 1ns/1ps

module tb_t1_idle_tracker;

    logic clock = 1'b0;
    logic reset = 1'b0;

    logic init_a = 1'b0, ar_a = 1'b0, rl_a = 1'b0, aw_a = 1'b0, b_a = 1'b0;
    logic busy_a = 1'b0, quit_a = 1'b0;
    logic idle_a, err_a;
    logic [7:0] rd_a, wr_a;
    logic [1:0] code_a;

    logic init_b = 1'b0, ar_b = 1'b0, rl_b = 1'b0, aw_b = 1'b0, b_b = 1'b0;
    logic busy_b = 1'b0, quit_b = 1'b0;
    logic idle_b, err_b;
    logic [1:0] rd_b, wr_b;
    logic [1:0] code_b;

`ifdef T1_IDLE_TRACKER_STATS_EN
    logic [63:0] rdt_a, wrt_a, dc_a, rdt_b, wrt_b, dc_b;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    t1_idle_tracker #(.OUTSTANDING_W(8), .QUIET_CYCLES(16)) dut (
        .clock          (clock),
        .reset          (reset),
        .initFlag       (init_a),
        .ar_fire        (ar_a),
        .r_last_fire    (rl_a),
        .aw_fire        (aw_a),
        .b_fire         (b_a),
        .core_busy      (busy_a),
        .quit           (quit_a),
        .idle           (idle_a),
        .rd_outstanding (rd_a),
        .wr_outstanding (wr_a),
        .error          (err_a),
        .error_code     (code_a)
`ifdef T1_IDLE_TRACKER_STATS_EN
        ,
        .rd_total       (rdt_a),
        .wr_total       (wrt_a),
        .drain_cycles   (dc_a)
`endif
    );

    t1_idle_tracker #(.OUTSTANDING_W(2), .QUIET_CYCLES(3)) dut_small (
        .clock          (clock),
        .reset          (reset),
        .initFlag       (init_b),
        .ar_fire        (ar_b),
        .r_last_fire    (rl_b),
        .aw_fire        (aw_b),
        .b_fire         (b_b),
        .core_busy      (busy_b),
        .quit           (quit_b),
        .idle           (idle_b),
        .rd_outstanding (rd_b),
        .wr_outstanding (wr_b),
        .error          (err_b),
        .error_code     (code_b)
`ifdef T1_IDLE_TRACKER_STATS_EN
        ,
        .rd_total       (rdt_b),
        .wr_total       (wrt_b),
        .drain_cycles   (dc_b)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges; outputs are settled 1 ns after the last one
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    initial begin
        #1;
        do_reset();

        // Reset values
        check("rst_idle", idle_a, 0);
        check("rst_rd",   rd_a,   0);
        check("rst_wr",   wr_a,   0);
        check("rst_err",  err_a,  0);
        check("rst_code", code_a, 0);

        // Simple drain: three reads open and close, then quit with a quiet bus
        ar_a = 1; step(3); ar_a = 0;
        check("rd_after_3ar", rd_a, 3);
        rl_a = 1; step(3); rl_a = 0;
        check("rd_after_3rl", rd_a, 0);
        quit_a = 1;
        step(16);
        check("drain_idle_early", idle_a, 0);
        step(1);
        check("drain_idle_high", idle_a, 1);

        // quit low drops idle on the next edge
        quit_a = 0; step(1);
        check("quit_low_idle", idle_a, 0);

        // Fire in the last quiet cycle restarts the count
        quit_a = 1; step(1);      // RUN -> DRAIN
        step(15);                 // quiet_cnt reaches 15
        aw_a = 1; step(1); aw_a = 0;
        check("last_quiet_fire_idle", idle_a, 0);
        check("wr_open", wr_a, 1);
        step(3);
        b_a = 1; step(1); b_a = 0;
        check("wr_closed", wr_a, 0);
        check("restart_no_idle", idle_a, 0);
        step(15);
        check("restart_idle_early", idle_a, 0);
        step(1);
        check("restart_idle_high", idle_a, 1);

        // Leaving IDLE: core_busy pulse, then quit low back to RUN
        busy_a = 1; step(1); busy_a = 0;
        check("busy_drop_idle", idle_a, 0);
        step(2);
        check("redrain_idle", idle_a, 0);
        quit_a = 0; step(1);
        quit_a = 1;
        step(16);
        check("from_run_idle_early", idle_a, 1'b0);
        step(1);
        check("from_run_idle_high", idle_a, 1);

        // initFlag forces RUN and clears the counters
        quit_a = 0;
        ar_a = 1; step(2); ar_a = 0;
        check("rd_before_init", rd_a, 2);
        quit_a = 1;
        init_a = 1; step(1);
        check("init_rd", rd_a, 0);
        step(20);
        check("init_hold_idle", idle_a, 0);
        init_a = 0; quit_a = 0; step(1);

        // Net-zero: issue and retire together every cycle with one open read
        ar_a = 1; step(1);
        check("rd_one", rd_a, 1);
        rl_a = 1; step(100); ar_a = 0; rl_a = 0;
        check("netzero_rd",  rd_a,  1);
        check("netzero_err", err_a, 0);

        // Underflow, then a later overflow keeps code 1
        rl_a = 1; step(1);                  // rd 1 -> 0
        step(1); rl_a = 0;                  // retire at zero
        check("uf_rd",   rd_a,   0);
        check("uf_err",  err_a,  1);
        check("uf_code", code_a, 1);
        ar_a = 1; step(256); ar_a = 0;
        check("sat_rd",       rd_a,   255);
        check("uf_code_kept", code_a, 1);

        // initFlag does not clear the sticky error
        init_a = 1; step(1); init_a = 0;
        check("init_keeps_err", err_a, 1);

        // Reset mid-DRAIN clears everything on the next edge
        quit_a = 1;
        aw_a = 1; step(2); aw_a = 0;
        step(1);
        check("middrain_wr", wr_a, 2);
        reset = 1; step(1); reset = 0;
        check("mid_rst_idle", idle_a, 0);
        check("mid_rst_rd",   rd_a,   0);
        check("mid_rst_wr",   wr_a,   0);
        check("mid_rst_err",  err_a,  0);
        check("mid_rst_code", code_a, 0);
        quit_a = 0;

        // Small instance: overflow at W=2
        ar_b = 1; step(4); ar_b = 0;
        check("ovf_rd",   rd_b,   3);
        check("ovf_err",  err_b,  1);
        check("ovf_code", code_b, 2);

        // Simultaneous underflow (writes) and overflow (reads): code 1 wins
        do_reset();
        ar_b = 1; step(3);
        check("sim_rd_full", rd_b,  3);
        check("sim_err_pre", err_b, 0);
        b_b = 1; step(1); ar_b = 0; b_b = 0;
        check("sim_code", code_b, 1);
        check("sim_rd",   rd_b,   3);
        check("sim_wr",   wr_b,   0);

        // Minimum-style drain on the small instance
        do_reset();
        quit_b = 1;
        step(3);
        check("small_idle_early", idle_b, 0);
        step(1);
        check("small_idle_high", idle_b, 1);
        quit_b = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
